adv_timer_capture: RTL and testbench

PWM input-capture unit, the receiving end of the advanced timer's pwm_o output.
- Measures period and active (high) time of one PWM line in prescaled clock ticks.
- Pushes each completed measurement into a 2-entry result buffer drained over a valid/ready handshake.
- Sits beside the advanced timer and is used for loopback and self-check of generated waveforms.

---
 rtl/adv_timer_capture_pkg.sv | 26 ++
 rtl/adv_timer_capture_fifo.sv | 65 ++++++
 rtl/adv_timer_capture.sv | 205 ++++++++++++++++++++
 tb/tb_adv_timer_capture.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adv_timer_capture_pkg.sv
// Shared types and constants for the PWM input-capture unit.
package adv_timer_capture_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    HIGH       = 2'd2,
    LOW        = 2'd3
  } cap_state_e;

  // Bit positions inside status_o.
  localparam int unsigned STS_ACTIVE  = 0;
  localparam int unsigned STS_DROP    = 1;
  localparam int unsigned STS_TIMEOUT = 2;
  localparam int unsigned STS_OVF     = 3;

  // Default result width; the top re-declares the record at its own NUM_BITS.
  localparam int unsigned MEAS_NUM_BITS = 16;

  typedef struct packed {
    logic [MEAS_NUM_BITS-1:0] period;
    logic [MEAS_NUM_BITS-1:0] high;
    logic                     ovf;
  } meas_t;

endpackage

// File: rtl/adv_timer_capture_fifo.sv
// Two-entry registered result buffer with valid/ready drain, flush and
// push-drop indication. The head entry is always held in slot0.
module adv_timer_capture_fifo #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             push_drop_o,
  input  logic             pop_ready_i,
  output logic             empty_o,
  output logic [WIDTH-1:0] pop_data_o
);

  logic [WIDTH-1:0] slot0_q, slot1_q, slot0_d, slot1_d;
  logic [1:0]       count_q, count_d;
  logic             full, pop, accept;

  assign empty_o     = (count_q == 2'd0);
  assign full        = (count_q == 2'd2);
  assign pop         = !empty_o && pop_ready_i;
  // A pop in the same cycle frees the slot the push needs.
  assign accept      = push_i && (!full || pop);
  assign push_drop_o = push_i && !accept && !flush_i;
  assign pop_data_o  = slot0_q;

  // Next slot contents: shift on pop, then append behind whatever remains.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      if (accept) begin
        if (count_d == 2'd0) begin
          slot0_d = push_data_i;
        end else begin
          slot1_d = push_data_i;
        end
        count_d = count_d + 2'd1;
      end
    end
  end

  // Buffer storage registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/adv_timer_capture.sv
// PWM input capture: measures period and active time of pwm_i in prescaled
// ticks and queues each completed measurement in a 2-entry buffer.
module adv_timer_capture
  import adv_timer_capture_pkg::*;
#(
  parameter int unsigned NUM_BITS    = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_start_i,
  input  logic                cfg_stop_i,
  input  logic                cfg_pol_i,
  input  logic [7:0]          cfg_presc_i,
  input  logic [NUM_BITS-1:0] cfg_timeout_i,
  input  logic                pwm_i,
  output logic                meas_valid_o,
  input  logic                meas_ready_i,
  output logic [NUM_BITS-1:0] meas_period_o,
  output logic [NUM_BITS-1:0] meas_high_o,
  output logic                meas_ovf_o,
  output logic [3:0]          status_o
);

  typedef struct packed {
    logic [NUM_BITS-1:0] period;
    logic [NUM_BITS-1:0] high;
    logic                ovf;
  } result_t;

  localparam int unsigned RES_W  = $bits(result_t);
  localparam int unsigned SYNC_N = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;

  cap_state_e          state_q, state_d;
  logic [SYNC_N-1:0]   sync_q;
  logic                sync_d_q;
  logic                sig, sig_d;
  logic                ref_edge_q, act_end_q;
  logic [7:0]          presc_q;
  logic                tick;
  logic [NUM_BITS-1:0] cnt_q, cnt_next, high_q;
  logic                ovf_q, ovf_now;
  logic                timeout_hit;
  logic                ctl_run, push, cnt_clr, snap_high, to_set;
  logic                sticky_drop_q, sticky_to_q, sticky_ovf_q;
  logic                fifo_flush, fifo_drop, fifo_empty;
  logic [RES_W-1:0]    fifo_dout;
  result_t             push_rec, head_rec;

  assign sig   = sync_q[SYNC_N-1] ^ cfg_pol_i;
  assign sig_d = sync_d_q ^ cfg_pol_i;

  // Synchronizer chain plus registered reference/active-end edge flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      sync_d_q   <= 1'b0;
      ref_edge_q <= 1'b0;
      act_end_q  <= 1'b0;
    end else begin
      sync_q[0] <= pwm_i;
      for (int unsigned i = 1; i < SYNC_N; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      sync_d_q   <= sync_q[SYNC_N-1];
      ref_edge_q <= sig && !sig_d;
      act_end_q  <= !sig && sig_d;
    end
  end

  assign tick = (state_q != IDLE) && (presc_q == cfg_presc_i);

  // Tick prescaler, parked at zero while idle.
  always_ff @(posedge clk_i) begin
    if (rst_i || cfg_start_i || state_q == IDLE || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 8'd1;
    end
  end

  assign cnt_next    = (cnt_q == '1) ? cnt_q : cnt_q + NUM_BITS'(tick);
  assign ovf_now     = ovf_q || (cnt_next == '1);
  assign timeout_hit = (cfg_timeout_i != '0) && (cnt_next >= cfg_timeout_i);

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; stop beats start, and an edge beats a timeout.
  always_comb begin
    state_d = state_q;
    if (cfg_stop_i) begin
      state_d = IDLE;
    end else if (cfg_start_i) begin
      state_d = WAIT_FIRST;
    end else begin
      case (state_q)
        IDLE:       state_d = IDLE;
        WAIT_FIRST: if (ref_edge_q) state_d = HIGH;
        HIGH: begin
          if (act_end_q)        state_d = LOW;
          else if (timeout_hit) state_d = WAIT_FIRST;
        end
        LOW: begin
          if (ref_edge_q)       state_d = HIGH;
          else if (timeout_hit) state_d = WAIT_FIRST;
        end
        default:    state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: counter control, snapshot, push and timeout event.
  always_comb begin
    ctl_run   = !cfg_stop_i && !cfg_start_i;
    push      = 1'b0;
    cnt_clr   = 1'b0;
    snap_high = 1'b0;
    to_set    = 1'b0;
    if (ctl_run) begin
      case (state_q)
        WAIT_FIRST: cnt_clr = ref_edge_q;
        HIGH: begin
          snap_high = act_end_q;
          to_set    = !act_end_q && timeout_hit;
        end
        LOW: begin
          push    = ref_edge_q;
          cnt_clr = ref_edge_q;
          to_set  = !ref_edge_q && timeout_hit;
        end
        default: ;
      endcase
    end
  end

  // Tick counter, measurement overflow flag and active-time snapshot.
  always_ff @(posedge clk_i) begin
    if (rst_i || cfg_start_i) begin
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      high_q <= '0;
    end else begin
      if (cnt_clr) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (state_q != IDLE) begin
        cnt_q <= cnt_next;
        ovf_q <= ovf_now;
      end
      if (snap_high) begin
        high_q <= cnt_next;
      end
    end
  end

  // Sticky status bits, cleared by reset and by an accepted start.
  always_ff @(posedge clk_i) begin
    if (rst_i || (cfg_start_i && !cfg_stop_i)) begin
      sticky_drop_q <= 1'b0;
      sticky_to_q   <= 1'b0;
      sticky_ovf_q  <= 1'b0;
    end else begin
      if (fifo_drop)        sticky_drop_q <= 1'b1;
      if (to_set)           sticky_to_q   <= 1'b1;
      if (push && ovf_now)  sticky_ovf_q  <= 1'b1;
    end
  end

  assign push_rec = '{period: cnt_next, high: high_q, ovf: ovf_now};
  // A simultaneous stop makes the start a no-op, buffer included.
  assign fifo_flush = cfg_start_i && !cfg_stop_i;

  adv_timer_capture_fifo #(
    .WIDTH(RES_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (fifo_flush),
    .push_i      (push),
    .push_data_i (push_rec),
    .push_drop_o (fifo_drop),
    .pop_ready_i (meas_ready_i),
    .empty_o     (fifo_empty),
    .pop_data_o  (fifo_dout)
  );

  assign head_rec      = result_t'(fifo_dout);
  assign meas_valid_o  = !fifo_empty;
  assign meas_period_o = head_rec.period;
  assign meas_high_o   = head_rec.high;
  assign meas_ovf_o    = head_rec.ovf;

  assign status_o[STS_ACTIVE]  = (state_q != IDLE);
  assign status_o[STS_DROP]    = sticky_drop_q;
  assign status_o[STS_TIMEOUT] = sticky_to_q;
  assign status_o[STS_OVF]     = sticky_ovf_q;

endmodule

// File: tb/tb_adv_timer_capture.sv
// Bench for adv_timer_capture: directed table of waveforms, hand sequences
// for stall/drop, timeout, stop, reset and narrow-counter overflow, and
// randomized waveforms checked against an arithmetic model of edge timing.
module tb_adv_timer_capture;
  import adv_timer_capture_pkg::*;

  localparam int unsigned SYNC_STAGES = 2;

  logic        clk, rst;
  logic        cfg_start, cfg_stop, cfg_pol;
  logic [7:0]  cfg_presc;
  logic [15:0] cfg_timeout;
  logic        pwm, pwm4;
  logic        meas_valid, meas_ready, meas_ovf;
  logic [15:0] meas_period, meas_high;
  logic [3:0]  status;
  logic        meas_valid4, ready4, meas_ovf4;
  logic [3:0]  meas_period4, meas_high4, status4;

  logic [1:0]  ready_mode;   // 0: hold low, 1: hold high, 2: random
  int unsigned stall;
  meas_t       got_q[$];
  meas_t       got4_q[$];
  meas_t       exp_q[$];
  int unsigned got_rd;
  int unsigned n_vec, n_err;

  adv_timer_capture #(
    .NUM_BITS(16),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .cfg_start_i(cfg_start), .cfg_stop_i(cfg_stop),
    .cfg_pol_i(cfg_pol), .cfg_presc_i(cfg_presc), .cfg_timeout_i(cfg_timeout),
    .pwm_i(pwm), .meas_valid_o(meas_valid), .meas_ready_i(meas_ready),
    .meas_period_o(meas_period), .meas_high_o(meas_high), .meas_ovf_o(meas_ovf),
    .status_o(status)
  );

  adv_timer_capture #(
    .NUM_BITS(4),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_dut4 (
    .clk_i(clk), .rst_i(rst), .cfg_start_i(cfg_start), .cfg_stop_i(cfg_stop),
    .cfg_pol_i(cfg_pol), .cfg_presc_i(cfg_presc), .cfg_timeout_i(cfg_timeout[3:0]),
    .pwm_i(pwm4), .meas_valid_o(meas_valid4), .meas_ready_i(ready4),
    .meas_period_o(meas_period4), .meas_high_o(meas_high4), .meas_ovf_o(meas_ovf4),
    .status_o(status4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Consumer: drives ready and records every handshake that the next edge completes.
  always @(negedge clk) begin
    case (ready_mode)
      2'd0:    meas_ready = 1'b0;
      2'd1:    meas_ready = 1'b1;
      default: meas_ready = (stall >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
    endcase
    if (meas_valid && meas_ready) begin
      got_q.push_back({meas_period, meas_high, meas_ovf});
      stall = 0;
    end else if (meas_valid) begin
      stall = stall + 1;
    end else begin
      stall = 0;
    end
    if (meas_valid4 && ready4) begin
      got4_q.push_back({12'd0, meas_period4, 12'd0, meas_high4, meas_ovf4});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_results(input string name);
    meas_t r_got, r_exp;
    check({name, "_count"}, 32'(got_q.size() - got_rd), 32'(exp_q.size()));
    while (exp_q.size() != 0 && got_rd < got_q.size()) begin
      r_exp = exp_q.pop_front();
      r_got = got_q[got_rd];
      got_rd++;
      check({name, "_period"}, 32'(r_got.period), 32'(r_exp.period));
      check({name, "_high"},   32'(r_got.high),   32'(r_exp.high));
      check({name, "_ovf"},    32'(r_got.ovf),    32'(r_exp.ovf));
    end
    exp_q.delete();
    got_rd = got_q.size();
  endtask

  task automatic phase(input bit sel4, input bit active, input int unsigned clocks);
    if (sel4) pwm4 = active ^ cfg_pol;
    else      pwm  = active ^ cfg_pol;
    repeat (clocks) @(negedge clk);
  endtask

  task automatic run_period(input bit sel4, input int unsigned p, input int unsigned h,
                            input int unsigned cpt);
    phase(sel4, 1'b1, h * cpt);
    phase(sel4, 1'b0, (p - h) * cpt);
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic pulse_stop();
    cfg_stop = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0;
  endtask

  task automatic setup(input logic [7:0] presc, input bit pol);
    cfg_presc = presc;
    cfg_pol   = pol;
    pwm       = pol;
    pwm4      = pol;
    repeat (5) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  presc;
    bit          pol;
    int unsigned per;
    int unsigned hi;
    int unsigned n;
    int unsigned exp_per;
    int unsigned exp_hi;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int unsigned cpt, lat, p, h;
    bit found;
    n_vec = 0; n_err = 0; got_rd = 0;
    rst = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_pol = 1'b0;
    cfg_presc = '0; cfg_timeout = '0; pwm = 1'b0; pwm4 = 1'b0;
    ready_mode = 2'd0; ready4 = 1'b1;

    tbl[0] = '{8'd0, 1'b0, 10,  3, 3, 10,  3};
    tbl[1] = '{8'd3, 1'b0, 10,  3, 2, 10,  3};
    tbl[2] = '{8'd3, 1'b1, 10,  3, 2, 10,  3};
    tbl[3] = '{8'd0, 1'b1,  2,  1, 4,  2,  1};
    tbl[4] = '{8'd1, 1'b0,  9,  8, 2,  9,  8};
    tbl[5] = '{8'd0, 1'b0, 300, 1, 1, 300, 1};

    repeat (3) @(negedge clk);
    check("rst_valid",  32'(meas_valid),  0);
    check("rst_period", 32'(meas_period), 0);
    check("rst_high",   32'(meas_high),   0);
    check("rst_ovf",    32'(meas_ovf),    0);
    check("rst_status", 32'(status),      0);
    rst = 1'b0;
    @(negedge clk);

    // Directed waveform table.
    ready_mode = 2'd1;
    foreach (tbl[i]) begin
      cpt = 32'(tbl[i].presc) + 1;
      setup(tbl[i].presc, tbl[i].pol);
      pulse_start();
      phase(1'b0, 1'b0, 2);
      for (int unsigned k = 0; k < tbl[i].n; k++) begin
        run_period(1'b0, tbl[i].per, tbl[i].hi, cpt);
        exp_q.push_back('{period: 16'(tbl[i].exp_per), high: 16'(tbl[i].exp_hi), ovf: 1'b0});
      end
      phase(1'b0, 1'b1, cpt);
      phase(1'b0, 1'b0, cpt);
      repeat (10) @(negedge clk);
      pulse_stop();
      check_results($sformatf("tbl%0d", i));
    end

    // Result latency from the sampling edge of the closing reference edge.
    setup(8'd0, 1'b0);
    pulse_start();
    phase(1'b0, 1'b0, 2);
    phase(1'b0, 1'b1, 3);
    phase(1'b0, 1'b0, 7);
    pwm = 1'b1;
    lat = 0; found = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (!found && meas_valid) begin
        found = 1'b1;
        lat = 32'(k);
      end
    end
    check("latency", lat, SYNC_STAGES + 2);
    phase(1'b0, 1'b0, 4);
    pulse_stop();
    exp_q.push_back('{period: 16'd10, high: 16'd3, ovf: 1'b0});
    check_results("lat");

    // Stalled consumer over 5 periods: two kept, three dropped.
    ready_mode = 2'd0;
    setup(8'd0, 1'b0);
    pulse_start();
    phase(1'b0, 1'b0, 2);
    for (int unsigned k = 0; k < 5; k++) run_period(1'b0, 10, 2 + k, 1);
    phase(1'b0, 1'b1, 1);
    phase(1'b0, 1'b0, 6);
    check("stall_valid",  32'(meas_valid),  1);
    check("stall_hold",   32'(meas_high),   2);
    check("stall_drop",   32'(status[1]),   1);
    ready_mode = 2'd1;
    repeat (4) @(negedge clk);
    exp_q.push_back('{period: 16'd10, high: 16'd2, ovf: 1'b0});
    exp_q.push_back('{period: 16'd10, high: 16'd3, ovf: 1'b0});
    check_results("drain");
    check("drop_sticky", 32'(status[1]), 1);
    pulse_start();
    check("drop_clear",  32'(status[1]), 0);
    pulse_stop();

    // Timeout with the line stuck active, then recovery from WAIT_FIRST.
    cfg_timeout = 16'd20;
    setup(8'd0, 1'b0);
    pulse_start();
    phase(1'b0, 1'b0, 2);
    phase(1'b0, 1'b1, 10);
    check("to_early",  32'(status[2]), 0);
    repeat (25) @(negedge clk);
    check("to_set",    32'(status[2]), 1);
    check("to_active", 32'(status[0]), 1);
    check("to_novalid", 32'(meas_valid), 0);
    phase(1'b0, 1'b0, 7);
    run_period(1'b0, 10, 3, 1);
    phase(1'b0, 1'b1, 1);
    phase(1'b0, 1'b0, 6);
    exp_q.push_back('{period: 16'd10, high: 16'd3, ovf: 1'b0});
    check_results("to_recover");
    pulse_start();
    check("to_clear", 32'(status[2]), 0);
    pulse_stop();
    cfg_timeout = '0;

    // Saturation on the 4-bit instance.
    setup(8'd0, 1'b0);
    pulse_start();
    phase(1'b1, 1'b0, 3);
    run_period(1'b1, 20, 5, 1);
    run_period(1'b1, 20, 5, 1);
    phase(1'b1, 1'b1, 1);
    phase(1'b1, 1'b0, 8);
    check("sat_count", 32'(got4_q.size()), 2);
    foreach (got4_q[i]) begin
      check("sat_period", 32'(got4_q[i].period), 15);
      check("sat_high",   32'(got4_q[i].high),   5);
      check("sat_ovf",    32'(got4_q[i].ovf),    1);
    end
    check("sat_sticky", 32'(status4[3]), 1);
    pulse_stop();

    // Stop during the inactive phase keeps the buffered result.
    ready_mode = 2'd0;
    setup(8'd0, 1'b0);
    pulse_start();
    phase(1'b0, 1'b0, 2);
    run_period(1'b0, 10, 3, 1);
    phase(1'b0, 1'b1, 3);
    phase(1'b0, 1'b0, 4);
    pulse_stop();
    check("stop_idle",   32'(status[0]),   0);
    check("stop_valid",  32'(meas_valid),  1);
    check("stop_period", 32'(meas_period), 10);
    phase(1'b0, 1'b1, 3);
    phase(1'b0, 1'b0, 6);
    ready_mode = 2'd1;
    repeat (3) @(negedge clk);
    exp_q.push_back('{period: 16'd10, high: 16'd3, ovf: 1'b0});
    check_results("stop");

    // Start and stop together: stop wins.
    pulse_start();
    @(negedge clk);
    check("ss_active", 32'(status[0]), 1);
    cfg_start = 1'b1; cfg_stop = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0; cfg_stop = 1'b0;
    check("ss_idle", 32'(status[0]), 0);

    // Reset mid-HIGH with an entry buffered.
    ready_mode = 2'd0;
    setup(8'd0, 1'b0);
    pulse_start();
    phase(1'b0, 1'b0, 2);
    run_period(1'b0, 10, 3, 1);
    phase(1'b0, 1'b1, 6);
    check("prerst_valid", 32'(meas_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_valid",  32'(meas_valid),  0);
    check("mrst_period", 32'(meas_period), 0);
    check("mrst_high",   32'(meas_high),   0);
    check("mrst_status", 32'(status),      0);
    rst = 1'b0;
    pwm = 1'b0;
    repeat (3) @(negedge clk);

    // Randomized waveforms: each closed period should read back its tick lengths.
    ready_mode = 2'd2;
    for (int it = 0; it < 4; it++) begin
      setup(8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      cpt = 32'(cfg_presc) + 1;
      pulse_start();
      phase(1'b0, 1'b0, 2);
      for (int k = 0; k < 6; k++) begin
        p = $urandom_range(4, 12);
        h = $urandom_range(1, p - 1);
        run_period(1'b0, p, h, cpt);
        exp_q.push_back('{period: 16'(p), high: 16'(h), ovf: 1'b0});
      end
      phase(1'b0, 1'b1, cpt);
      phase(1'b0, 1'b0, cpt);
      repeat (12) @(negedge clk);
      check("rand_drop", 32'(status[1]), 0);
      pulse_stop();
      check_results($sformatf("rand%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
